// File: rtl/mau_rx_queue.sv
// rtl/mau_rx_queue.sv - SPI byte assembler feeding a show-ahead instruction frame FIFO
// Bytes arrive on an asynchronous SPI strobe, are synchronised into clk and packed MSB-first.
module mau_rx_queue #(
   parameter int DATA_W      = 8,
   parameter int FRAME_BYTES = 5,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              spi_clk,
   input  logic                              spi_w,
   input  logic [DATA_W-1:0]                 mosi,
   output logic [DATA_W*FRAME_BYTES-1:0]     frame_q,
   output logic                              frame_valid,
   input  logic                              frame_ready,
   output logic [$clog2(DEPTH+1)-1:0]        level,
   output logic                              overflow,
   input  logic                              clr_overflow,
   output logic                              frame_abort
);

   localparam int FW = DATA_W * FRAME_BYTES;
   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int CW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_BYTES - 1);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] w_sync;
   logic [DATA_W-1:0]      mosi_sync [SYNC_STAGES];
   logic                   clk_d;
   logic                   w_d;

   // mosi travels through the same depth as spi_clk so the byte is stable at the detected edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync <= '0;
         w_sync   <= '0;
         clk_d    <= 1'b0;
         w_d      <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) mosi_sync[i] <= '0;
      end else begin
         clk_sync     <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
         w_sync       <= {w_sync[SYNC_STAGES-2:0], spi_w};
         mosi_sync[0] <= mosi;
         for (int i = 1; i < SYNC_STAGES; i++) mosi_sync[i] <= mosi_sync[i-1];
         clk_d        <= clk_sync[SYNC_STAGES-1];
         w_d          <= w_sync[SYNC_STAGES-1];
      end
   end

   logic              clk_s;
   logic              w_s;
   logic [DATA_W-1:0] mosi_s;
   logic [CW-1:0]     byte_cnt;
   logic [FW-1:0]     asm_q;
   logic [FW-1:0]     asm_next;
   logic              capture;
   logic              abort_det;
   logic              last_byte;

   assign clk_s     = clk_sync[SYNC_STAGES-1];
   assign w_s       = w_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign capture   = clk_s & ~clk_d & w_s;
   assign abort_det = w_d & ~w_s & (byte_cnt != '0);
   assign last_byte = capture & (byte_cnt == LAST_CNT);
   assign asm_next  = (asm_q << DATA_W) | FW'(mosi_s);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt    <= '0;
         asm_q       <= '0;
         frame_abort <= 1'b0;
      end else begin
         frame_abort <= abort_det;
         if (abort_det) begin
            byte_cnt <= '0;
            asm_q    <= '0;
         end else if (capture) begin
            asm_q    <= asm_next;
            byte_cnt <= last_byte ? '0 : byte_cnt + CW'(1);
         end
      end
   end

   logic [FW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          full;
   logic          pop;
   logic          push;
   logic          drop;

   assign frame_valid = (level != '0);
   assign full        = (level == FULL_LVL);
   assign pop         = frame_valid & frame_ready;
   // a pop in the same cycle frees the slot the full-FIFO push needs
   assign push        = last_byte & (~full | pop);
   assign drop        = last_byte & full & ~pop;
   assign frame_q     = frame_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= asm_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         if (drop)              overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mau_rx_queue.sv
// tb/tb_mau_rx_queue.sv - vector table, corner sequences and randomized queue-model checks for mau_rx_queue
module tb_mau_rx_queue;

   localparam int DATA_W      = 8;
   localparam int FRAME_BYTES = 5;
   localparam int DEPTH       = 4;
   localparam int SYNC_STAGES = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        spi_clk = 1'b0;
   logic        spi_w = 1'b0;
   logic [7:0]  mosi = 8'h00;
   logic        frame_ready = 1'b0;
   logic        clr_overflow = 1'b0;
   logic [39:0] frame_q;
   logic        frame_valid;
   logic [2:0]  level;
   logic        overflow;
   logic        frame_abort;

   int vectors = 0;
   int miscompares = 0;
   int abort_seen = 0;

   logic [39:0] model_q [$];
   logic        model_ovf;

   typedef struct {
      logic [39:0] data;
      int          nbytes;
      int          npop;
      int          exp_abort;
      int          exp_level;
      logic [39:0] exp_q;
   } vec_t;

   vec_t tbl [5];

   mau_rx_queue #(
      .DATA_W(DATA_W), .FRAME_BYTES(FRAME_BYTES), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_w(spi_w), .mosi(mosi),
      .frame_q(frame_q), .frame_valid(frame_valid), .frame_ready(frame_ready),
      .level(level), .overflow(overflow), .clr_overflow(clr_overflow),
      .frame_abort(frame_abort)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_abort) abort_seen++;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(logic [7:0] b);
      mosi = b;
      tick(1);
      spi_clk = 1'b1;
      tick(4);
      spi_clk = 1'b0;
      tick(4);
   endtask

   // returns the number of cycles frame_abort was seen high after spi_w drops
   task automatic burst(logic [39:0] d, int n, output int aborts);
      int a0;
      spi_w = 1'b1;
      tick(2);
      for (int i = 0; i < n; i++) send_byte(d[39-8*i -: 8]);
      a0 = abort_seen;
      spi_w = 1'b0;
      tick(SYNC_STAGES + 4);
      aborts = abort_seen - a0;
   endtask

   task automatic pop_one();
      frame_ready = 1'b1;
      tick(1);
      frame_ready = 1'b0;
   endtask

   task automatic fill_four();
      int a;
      for (int k = 1; k <= 4; k++) burst({8'(k), 32'h11223344}, 5, a);
   endtask

   initial begin
      int          a;
      int          a0;
      int          n;
      int          op;
      logic [39:0] d;
      logic [39:0] exp_head;

      tbl[0] = '{40'h0112345678, 5, 0, 0, 1, 40'h0112345678};
      tbl[1] = '{40'hAABBCC0000, 3, 0, 1, 1, 40'h0112345678};
      tbl[2] = '{40'hAABBCCDDEE, 5, 0, 0, 2, 40'h0112345678};
      tbl[3] = '{40'h0000000000, 0, 1, 0, 1, 40'hAABBCCDDEE};
      tbl[4] = '{40'h9900000000, 1, 1, 1, 0, 40'h0000000000};

      tick(3);
      check("reset frame_q", frame_q, 0);
      check("reset frame_valid", frame_valid, 0);
      check("reset level", level, 0);
      check("reset overflow", overflow, 0);
      check("reset frame_abort", frame_abort, 0);
      rst_n = 1'b1;
      tick(3);

      for (int i = 0; i < 5; i++) begin
         burst(tbl[i].data, tbl[i].nbytes, a);
         repeat (tbl[i].npop) pop_one();
         tick(1);
         check($sformatf("tbl%0d abort cycles", i), a, tbl[i].exp_abort);
         check($sformatf("tbl%0d level", i), level, tbl[i].exp_level);
         check($sformatf("tbl%0d frame_q", i), frame_q, tbl[i].exp_q);
         check($sformatf("tbl%0d frame_valid", i), frame_valid, (tbl[i].exp_level != 0) ? 1 : 0);
      end

      // overflow when full with no pop, then in-order drain and sticky clear
      fill_four();
      burst(40'h0511223344, 5, a);
      check("ovf overflow set", overflow, 1);
      check("ovf level", level, 4);
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("ovf drain op%0d", k), frame_q[39:32], k);
         pop_one();
      end
      check("ovf drained valid", frame_valid, 0);
      check("ovf sticky after drain", overflow, 1);
      clr_overflow = 1'b1;
      tick(1);
      clr_overflow = 1'b0;
      check("ovf cleared", overflow, 0);

      // last byte of a frame lands on the same edge as a pop of a full FIFO
      fill_four();
      spi_w = 1'b1;
      tick(2);
      for (int i = 0; i < 4; i++) send_byte(8'(40'h0511223344 >> (32 - 8*i)));
      mosi = 8'h44;
      tick(1);
      spi_clk = 1'b1;
      tick(SYNC_STAGES);
      frame_ready = 1'b1;
      tick(1);
      frame_ready = 1'b0;
      tick(2);
      spi_clk = 1'b0;
      tick(4);
      spi_w = 1'b0;
      tick(6);
      check("pushpop level", level, 4);
      check("pushpop overflow", overflow, 0);
      for (int k = 2; k <= 5; k++) begin
         check($sformatf("pushpop drain %0d", k), frame_q, {8'(k), 32'h11223344});
         pop_one();
      end
      check("pushpop drained valid", frame_valid, 0);

      // reset mid-frame with two frames queued
      burst(40'h0A0A0A0A0A, 5, a);
      burst(40'h0B0B0B0B0B, 5, a);
      check("mid-reset pre level", level, 2);
      a0 = abort_seen;
      spi_w = 1'b1;
      tick(2);
      send_byte(8'hC1);
      send_byte(8'hC2);
      rst_n = 1'b0;
      #1;
      check("mid-reset level", level, 0);
      check("mid-reset frame_q", frame_q, 0);
      spi_w = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(3);
      spi_w = 1'b1;
      tick(2);
      for (int i = 0; i < 4; i++) send_byte(8'(40'h123456789A >> (32 - 8*i)));
      mosi = 8'h9A;
      tick(1);
      spi_clk = 1'b1;
      tick(SYNC_STAGES + 2);
      check("latency frame_valid", frame_valid, 1);
      spi_clk = 1'b0;
      tick(4);
      spi_w = 1'b0;
      tick(6);
      check("post-reset frame_q", frame_q, 40'h123456789A);
      check("post-reset level", level, 1);
      check("post-reset no abort", abort_seen - a0, 0);
      pop_one();
      tick(1);

      // randomized operations against a frame-queue model
      model_q.delete();
      model_ovf = 1'b0;
      for (int it = 0; it < 40; it++) begin
         op = $urandom_range(0, 3);
         if (op == 0) begin
            pop_one();
            if (model_q.size() > 0) void'(model_q.pop_front());
         end else begin
            n = $urandom_range(1, 5);
            d[31:0]  = $urandom();
            d[39:32] = 8'($urandom_range(0, 255));
            burst(d, n, a);
            check($sformatf("rnd%0d abort", it), a, (n < 5) ? 1 : 0);
            if (n == 5) begin
               if (model_q.size() < DEPTH) model_q.push_back(d);
               else model_ovf = 1'b1;
            end
         end
         if ($urandom_range(0, 5) == 0) begin
            clr_overflow = 1'b1;
            tick(1);
            clr_overflow = 1'b0;
            model_ovf = 1'b0;
         end
         tick(1);
         exp_head = (model_q.size() > 0) ? model_q[0] : 40'h0;
         check($sformatf("rnd%0d level", it), level, model_q.size());
         check($sformatf("rnd%0d frame_valid", it), frame_valid, (model_q.size() > 0) ? 1 : 0);
         check($sformatf("rnd%0d frame_q", it), frame_q, exp_head);
         check($sformatf("rnd%0d overflow", it), overflow, model_ovf);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
